fetch_queue: RTL and testbench

//  Decoupled instruction fetch stage for the pipelined MIPS core: PC register + DEPTH-entry in-order

---
 rtl/fq_pkg.sv | 30 +++
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fq_predecode.sv | 32 +++
 rtl/fetch_queue.sv | 158 +++++++++++++++
 tb/tb_fetch_queue.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fq_pkg.sv
// Shared types and constants for the fetch queue.
// Entry bundle, exception codes and control-transfer opcodes.
package fq_pkg;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;

    localparam logic [4:0] RT_BLTZ = 5'h00;
    localparam logic [4:0] RT_BGEZ = 5'h01;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ds;
        logic [4:0]  exc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction memory request/response port of the fetch stage.
// master = fetch side, slave = memory side.
interface fetch_queue_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fq_predecode.sv
// Flags branches and jumps so the next fetched entry is marked
// as a delay slot.
module fq_predecode
    import fq_pkg::*;
(
    input  logic [31:0] ins,
    output logic        is_ctl
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;

    assign op = ins[31:26];
    assign fn = ins[5:0];
    assign rt = ins[20:16];

    always_comb begin
        is_ctl = 1'b0;
        case (op)
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                is_ctl = 1'b1;
            OP_REGIMM:
                is_ctl = (rt == RT_BLTZ) || (rt == RT_BGEZ);
            OP_SPECIAL:
                is_ctl = (fn == FN_JR) || (fn == FN_JALR);
            default:
                is_ctl = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch: PC, credit-limited imem requests, in-order decode queue.
// Optional FETCH_QUEUE_BYPASS_EN: empty-queue responses go straight to decode.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] TEXT_LO  = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI  = 32'h0000_6ffc
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master imem,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          irq_req,
    input  logic [31:0]   ebase,
    output logic          d_valid,
    input  logic          d_ready,
    output logic [31:0]   d_pc,
    output logic [31:0]   d_ins,
    output logic          d_ds,
    output logic [4:0]    d_exccode
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = CW + 2;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [DW-1:0] drop_cnt;
    logic [AW-1:0] q_wr, q_rd, f_wr, f_rd;
    logic          prev_ctl;

    fq_entry_t     q_mem [DEPTH];
    logic [31:0]   f_mem [DEPTH];
    fq_entry_t     last_q;

    fq_entry_t     push_e, out_e;
    logic          redirect, legal, credit, fire;
    logic          rsp_take, rsp_drop, ill_push;
    logic          push, pop, q_pop, bypass, is_ctl;

    assign redirect = irq_req | redirect_valid;
    assign legal    = (pc[1:0] == 2'b00) && (pc >= TEXT_LO) && (pc <= TEXT_HI);
    assign credit   = ({1'b0, count} + {1'b0, inflight}) < DEPTH_W;

    assign imem.imem_req_valid = !reset && legal && credit && !redirect;
    assign imem.imem_req_addr  = pc;
    assign fire = imem.imem_req_valid && imem.imem_req_ready;

    assign rsp_drop = imem.imem_rsp_valid && (drop_cnt != '0);
    assign rsp_take = imem.imem_rsp_valid && (drop_cnt == '0);
    // AdEL entries only once older responses are home, keeping order
    assign ill_push = !reset && !legal && credit && (inflight == '0) && !redirect;

    always_comb begin
        push_e = '0;
        if (rsp_take) begin
            push_e.pc  = f_mem[f_rd];
            push_e.ins = imem.imem_rsp_data;
            push_e.exc = EXC_NONE;
        end else begin
            push_e.pc  = pc;
            push_e.ins = 32'h0;
            push_e.exc = EXC_ADEL;
        end
        push_e.ds = prev_ctl;
    end

    fq_predecode u_predecode (
        .ins    (push_e.ins),
        .is_ctl (is_ctl)
    );

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = !reset && rsp_take && (count == '0) && d_ready && !redirect;
`else
    assign bypass = 1'b0;
`endif

    assign push = (rsp_take || ill_push) && !redirect && !bypass;

    always_comb begin
        d_valid = (count != '0) || bypass;
        out_e   = last_q;
        if (bypass)
            out_e = push_e;
        else if (count != '0)
            out_e = q_mem[q_rd];
    end

    assign d_pc      = out_e.pc;
    assign d_ins     = out_e.ins;
    assign d_ds      = out_e.ds;
    assign d_exccode = out_e.exc;

    assign pop   = d_valid && d_ready;
    assign q_pop = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (push)
            q_mem[q_wr] <= push_e;
        if (fire)
            f_mem[f_wr] <= pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            prev_ctl <= 1'b0;
            q_wr     <= '0;
            q_rd     <= '0;
            f_wr     <= '0;
            f_rd     <= '0;
            last_q   <= '0;
        end else begin
            if (pop)
                last_q <= out_e;
            if (redirect) begin
                pc       <= irq_req ? ebase : redirect_pc;
                count    <= '0;
                inflight <= '0;
                prev_ctl <= 1'b0;
                q_wr     <= '0;
                q_rd     <= '0;
                f_wr     <= '0;
                f_rd     <= '0;
                // everything still owed by memory is now stale
                drop_cnt <= drop_cnt - DW'(rsp_drop)
                            + DW'(inflight) - DW'(rsp_take);
            end else begin
                if (fire || ill_push)
                    pc <= pc + 32'd4;
                if (push)
                    q_wr <= q_wr + AW'(1);
                if (q_pop)
                    q_rd <= q_rd + AW'(1);
                if (fire)
                    f_wr <= f_wr + AW'(1);
                if (rsp_take)
                    f_rd <= f_rd + AW'(1);
                if (push || bypass)
                    prev_ctl <= is_ctl;
                count    <= count + CW'(push) - CW'(q_pop);
                inflight <= inflight + CW'(fire) - CW'(rsp_take);
                drop_cnt <= drop_cnt - DW'(rsp_drop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a
// randomized run checked against an in-order program-stream model.
`timescale 1ns/1ps
module tb_fetch_queue;
    import fq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid, irq_req, d_ready;
    logic [31:0] redirect_pc, ebase;
    logic        d_valid, d_ds;
    logic [31:0] d_pc, d_ins;
    logic [4:0]  d_exccode;

    fetch_queue_if bus();

    fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .irq_req        (irq_req),
        .ebase          (ebase),
        .d_valid        (d_valid),
        .d_ready        (d_ready),
        .d_pc           (d_pc),
        .d_ins          (d_ins),
        .d_ds           (d_ds),
        .d_exccode      (d_exccode)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          redir;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        ds;
        logic [4:0]  exc;
        int          c;
    } ev_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    int rdy_pct = 100;

    logic [31:0] prog [bit [31:0]];
    ev_t         evs [$];
    logic [31:0] reqs [$];
    logic [31:0] pend_a [$];
    int          pend_t [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (prog.exists(a)) return prog[a];
        if (a[4:2] == 3'd5) return 32'h1000_0002;
        if (a[6:2] == 5'd30) return 32'h03e0_0008;
        return 32'h3400_0000 | {16'h0, a[15:0]};
    endfunction

    function automatic bit legal_m(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a <= 32'h6ffc);
    endfunction

    function automatic bit is_ctl_m(input logic [31:0] w);
        case (w[31:26])
            6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7: return 1'b1;
            6'd1: return (w[20:16] == 5'd0) || (w[20:16] == 5'd1);
            6'd0: return (w[5:0] == 6'h08) || (w[5:0] == 6'h09);
            default: return 1'b0;
        endcase
    endfunction

    task automatic step(input bit rdy = 1'b1, input bit rv = 1'b0,
                        input logic [31:0] rpc = 32'h0, input bit irq = 1'b0,
                        input logic [31:0] eb = 32'h4180);
        ev_t e;
        @(negedge clk);
        d_ready = rdy;
        redirect_valid = rv;
        redirect_pc = rpc;
        irq_req = irq;
        ebase = eb;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data = word_of(pend_a[0]);
            void'(pend_t.pop_front());
            void'(pend_a.pop_front());
        end
        bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            reqs.push_back(bus.imem_req_addr);
            pend_a.push_back(bus.imem_req_addr);
            pend_t.push_back(cyc + lat);
        end
        if (d_valid && d_ready) begin
            e = '{redir: 1'b0, pc: d_pc, ins: d_ins, ds: d_ds, exc: d_exccode, c: cyc};
            evs.push_back(e);
        end
        if (rv || irq) begin
            e = '{redir: 1'b1, pc: (irq ? eb : rpc), ins: 32'h0, ds: 1'b0, exc: 5'd0, c: cyc};
            evs.push_back(e);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        d_ready = 1'b0;
        redirect_valid = 1'b0;
        irq_req = 1'b0;
        redirect_pc = 32'h0;
        ebase = 32'h4180;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        repeat (2) @(negedge clk);
        pend_a.delete();
        pend_t.delete();
        reqs.delete();
        evs.delete();
        cyc = 0;
        lat = 1;
        rdy_pct = 100;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (8) step();
        @(negedge clk);
        reset = 1'b1;
        d_ready = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid);
        end
        checks++;
        if (d_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_d_valid: got %b want 0", d_valid);
        end
        checks++;
        if ({d_pc, d_ins, d_ds, d_exccode} !== 70'h0) begin
            errors++;
            $display("FAIL reset_d_fields: got pc=%h ins=%h ds=%b exc=%0d want all 0",
                     d_pc, d_ins, d_ds, d_exccode);
        end
    endtask

    task automatic test_basic();
        int first_exp;
        do_reset();
        for (int i = 0; i < 20 && evs.size() < 3; i++) step();
        checks++;
        if (evs.size() < 3) begin
            errors++;
            $display("FAIL basic_timeout: got %0d pops want 3", evs.size());
        end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
            first_exp = lat;
`else
            first_exp = lat + 1;
`endif
            checks++;
            if (evs[0].c !== first_exp) begin
                errors++;
                $display("FAIL basic_latency: got cycle %0d want %0d", evs[0].c, first_exp);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (evs[k].pc !== 32'h3000 + 32'(4 * k) || evs[k].exc !== EXC_NONE
                    || evs[k].ins !== word_of(evs[k].pc) || evs[k].c !== first_exp + k) begin
                    errors++;
                    $display("FAIL basic_pop%0d: got pc=%h exc=%0d cyc=%0d want pc=%h exc=0 cyc=%0d",
                             k, evs[k].pc, evs[k].exc, evs[k].c, 32'h3000 + 32'(4 * k), first_exp + k);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (10) step(1'b0);
        checks++;
        if (reqs.size() !== 4) begin
            errors++;
            $display("FAIL bp_req_count: got %0d want 4", reqs.size());
        end
        checks++;
        if (bus.imem_req_addr !== 32'h3010 || bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_pc_hold: got addr=%h valid=%b want addr=00003010 valid=0",
                     bus.imem_req_addr, bus.imem_req_valid);
        end
        for (int i = 0; i < 30 && evs.size() < 4; i++) step(1'b1);
        checks++;
        if (evs.size() < 4) begin
            errors++;
            $display("FAIL bp_timeout: got %0d pops want 4", evs.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (evs[k].pc !== 32'h3000 + 32'(4 * k) || evs[k].ins !== word_of(evs[k].pc)) begin
                    errors++;
                    $display("FAIL bp_order%0d: got pc=%h ins=%h want pc=%h", k,
                             evs[k].pc, evs[k].ins, 32'h3000 + 32'(4 * k));
                end
            end
        end
    endtask

    task automatic test_delay_slot();
        prog[32'h3000] = 32'h1000_0003;
        do_reset();
        for (int i = 0; i < 20 && evs.size() < 3; i++) step();
        checks++;
        if (evs.size() < 3) begin
            errors++;
            $display("FAIL ds_timeout: got %0d pops want 3", evs.size());
        end else begin
            checks++;
            if (evs[0].ds !== 1'b0 || evs[1].ds !== 1'b1 || evs[2].ds !== 1'b0
                || evs[1].pc !== 32'h3004) begin
                errors++;
                $display("FAIL ds_bits: got %b%b%b pc1=%h want 010 pc1=00003004",
                         evs[0].ds, evs[1].ds, evs[2].ds, evs[1].pc);
            end
        end
        prog.delete();
    endtask

    task automatic test_redirect_drop();
        do_reset();
        lat = 4;
        repeat (3) step();
        checks++;
        if (reqs.size() !== 3) begin
            errors++;
            $display("FAIL drop_inflight: got %0d reqs want 3", reqs.size());
        end
        step(1'b1, 1'b1, 32'h3400);
        for (int i = 0; i < 40 && evs.size() < 4; i++) step();
        checks++;
        if (evs.size() < 4) begin
            errors++;
            $display("FAIL drop_timeout: got %0d events want 4", evs.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (evs[k].redir || evs[k].pc !== 32'h3400 + 32'(4 * (k - 1))
                    || evs[k].ins !== word_of(evs[k].pc) || evs[k].exc !== EXC_NONE) begin
                    errors++;
                    $display("FAIL drop_pop%0d: got pc=%h ins=%h want pc=%h", k,
                             evs[k].pc, evs[k].ins, 32'h3400 + 32'(4 * (k - 1)));
                end
            end
            checks++;
            if (evs[1].ds !== 1'b0 || reqs[3] !== 32'h3400) begin
                errors++;
                $display("FAIL drop_target: got ds=%b req=%h want ds=0 req=00003400",
                         evs[1].ds, reqs[3]);
            end
        end
    endtask

    task automatic test_irq();
        int idx;
        do_reset();
        repeat (5) step();
        step(1'b1, 1'b1, 32'h3400, 1'b1, 32'h4180);
        idx = evs.size();
        for (int i = 0; i < 20 && evs.size() <= idx; i++) step();
        checks++;
        if (evs.size() <= idx) begin
            errors++;
            $display("FAIL irq_timeout: got no pop want pc 00004180");
        end else if (evs[idx].pc !== 32'h4180 || evs[idx].ds !== 1'b0
                     || evs[idx].ins !== word_of(32'h4180)) begin
            errors++;
            $display("FAIL irq_target: got pc=%h ds=%b want pc=00004180 ds=0",
                     evs[idx].pc, evs[idx].ds);
        end
    endtask

    task automatic test_adel();
        logic [31:0] tgt [4];
        logic [31:0] nxt [4];
        bit          nxt_ok [4];
        int          idx, nreq;
        tgt = '{32'h3002, 32'h7000, 32'hffff_fffc, 32'h6ffc};
        nxt = '{32'h3006, 32'h7004, 32'h0000_0000, 32'h7000};
        nxt_ok = '{1'b0, 1'b0, 1'b0, 1'b0};
        for (int t = 0; t < 4; t++) begin
            do_reset();
            step(1'b1, 1'b1, tgt[t]);
            idx = evs.size();
            nreq = reqs.size();
            for (int i = 0; i < 20 && evs.size() < idx + 2; i++) step();
            checks++;
            if (evs.size() < idx + 2) begin
                errors++;
                $display("FAIL adel_timeout%0d: got %0d pops want 2", t, evs.size() - idx);
            end else begin
                checks++;
                if (evs[idx].pc !== tgt[t] || evs[idx].ds !== 1'b0
                    || evs[idx].exc !== (legal_m(tgt[t]) ? EXC_NONE : EXC_ADEL)
                    || evs[idx].ins !== (legal_m(tgt[t]) ? word_of(tgt[t]) : 32'h0)) begin
                    errors++;
                    $display("FAIL adel_first%0d: got pc=%h ins=%h exc=%0d want pc=%h",
                             t, evs[idx].pc, evs[idx].ins, evs[idx].exc, tgt[t]);
                end
                checks++;
                if (evs[idx + 1].pc !== nxt[t] || evs[idx + 1].exc !== EXC_ADEL
                    || evs[idx + 1].ins !== 32'h0 || nxt_ok[t]) begin
                    errors++;
                    $display("FAIL adel_next%0d: got pc=%h exc=%0d want pc=%h exc=4",
                             t, evs[idx + 1].pc, evs[idx + 1].exc, nxt[t]);
                end
            end
            checks++;
            if (reqs.size() - nreq !== (legal_m(tgt[t]) ? 1 : 0)) begin
                errors++;
                $display("FAIL adel_reqs%0d: got %0d requests want %0d", t,
                         reqs.size() - nreq, legal_m(tgt[t]) ? 1 : 0);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, rpc, eb, w;
        bit          prev, rv, irq, bad;
        int          npop;
        for (int l = 1; l <= 3; l++) begin
            do_reset();
            lat = l;
            rdy_pct = 70;
            for (int i = 0; i < 600; i++) begin
                rv = ($urandom_range(39) == 0);
                irq = ($urandom_range(79) == 0);
                case ($urandom_range(5))
                    0, 1, 2: rpc = 32'h3000 + ($urandom_range(4095) << 2);
                    3: rpc = 32'h6ff8;
                    4: rpc = 32'h3001 + ($urandom_range(255) << 2);
                    default: rpc = 32'h7000;
                endcase
                eb = ($urandom_range(1) == 0) ? 32'h4180 : 32'h3000 + ($urandom_range(255) << 2);
                step($urandom_range(9) < 7, rv, rpc, irq, eb);
            end
            exp_pc = 32'h3000;
            prev = 1'b0;
            npop = 0;
            bad = 1'b0;
            foreach (evs[i]) begin
                if (bad) break;
                if (evs[i].redir) begin
                    exp_pc = evs[i].pc;
                    prev = 1'b0;
                end else begin
                    w = legal_m(exp_pc) ? word_of(exp_pc) : 32'h0;
                    checks++;
                    if (evs[i].pc !== exp_pc || evs[i].ins !== w || evs[i].ds !== prev
                        || evs[i].exc !== (legal_m(exp_pc) ? EXC_NONE : EXC_ADEL)) begin
                        errors++;
                        bad = 1'b1;
                        $display("FAIL rand_L%0d_pop%0d: got pc=%h ins=%h ds=%b exc=%0d want pc=%h ins=%h ds=%b",
                                 l, npop, evs[i].pc, evs[i].ins, evs[i].ds, evs[i].exc, exp_pc, w, prev);
                    end
                    prev = is_ctl_m(w);
                    exp_pc = exp_pc + 32'd4;
                    npop++;
                end
            end
            checks++;
            if (npop < 50) begin
                errors++;
                $display("FAIL rand_L%0d_progress: got %0d pops want >= 50", l, npop);
            end
            foreach (reqs[i]) begin
                checks++;
                if (!legal_m(reqs[i])) begin
                    errors++;
                    $display("FAIL rand_L%0d_req_addr: got %h want legal text address", l, reqs[i]);
                    break;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        d_ready = 1'b0;
        redirect_valid = 1'b0;
        irq_req = 1'b0;
        redirect_pc = 32'h0;
        ebase = 32'h4180;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_delay_slot();
        test_redirect_drop();
        test_irq();
        test_adel();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
